// File: rtl/check_parity.sv
// Receive-side parity checker for words read back from RAM.
// Checks odd parity on each stored word, strips the parity bits, flags
// failing words per beat, and keeps sticky status, a saturating error
// counter and a snapshot of the first failing beat for diagnosis.
module check_parity #(
  parameter int WORDS         = 5,
  parameter int BITS_PER_WORD = 9,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [(BITS_PER_WORD+1)*WORDS-1:0] din,
  input  logic                               din_valid,
  input  logic                               clr_err,
  output logic [BITS_PER_WORD*WORDS-1:0]     dout,
  output logic                               dout_valid,
  output logic [WORDS-1:0]                   word_err,
  output logic                               any_err,
  output logic [WORDS-1:0]                   err_sticky,
  output logic [ERR_CNT_WIDTH-1:0]           err_count,
  output logic                               cap_valid,
  output logic [(BITS_PER_WORD+1)*WORDS-1:0] cap_data
);

  localparam int WORD_W = BITS_PER_WORD + 1;
  localparam int BEAT_W = WORD_W * WORDS;
  localparam int DATA_W = BITS_PER_WORD * WORDS;
  localparam int POP_W  = $clog2(WORDS + 1);

  // Stage 1 state
  logic [BEAT_W-1:0]        s1_data_reg;
  logic                     s1_valid_reg;

  // Stage 2 / output state
  logic [DATA_W-1:0]        dout_reg;
  logic                     dout_valid_reg;
  logic [WORDS-1:0]         word_err_reg;

  // Status state
  logic [WORDS-1:0]         err_sticky_reg, err_sticky_next;
  logic [ERR_CNT_WIDTH-1:0] err_count_reg, err_count_next;
  logic                     cap_valid_reg, cap_valid_next;
  logic [BEAT_W-1:0]        cap_data_reg, cap_data_next;

  // Combinational views of the stage-1 beat
  logic [WORDS-1:0]         err_vec;
  logic [WORDS-1:0]         err_hit;
  logic [DATA_W-1:0]        stripped;
  logic [POP_W-1:0]         err_pop;
  logic [ERR_CNT_WIDTH:0]   count_sum;

  // Per-word parity check and parity stripping on the registered beat
  generate
    for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
      // Odd parity: a good word XORs to 1, so XNOR-reduction flags a failure.
      assign err_vec[gi] = ~^s1_data_reg[gi*WORD_W +: WORD_W];
      assign stripped[gi*BITS_PER_WORD +: BITS_PER_WORD] =
        s1_data_reg[gi*WORD_W +: BITS_PER_WORD];
    end
  endgenerate

  // Only a valid beat may raise errors; idle cycles carry stale din.
  assign err_hit = s1_valid_reg ? err_vec : '0;

  // Count failing words in the beat about to leave stage 1
  always_comb begin
    err_pop = '0;
    for (int i = 0; i < WORDS; i++) begin
      err_pop = err_pop + POP_W'(err_hit[i]);
    end
  end

  // Next status: a clear wipes history, but the concurrent beat still lands
  always_comb begin
    err_sticky_next = (clr_err ? '0 : err_sticky_reg) | err_hit;

    // One extra bit of headroom so saturation is detected instead of wrapping.
    count_sum = {1'b0, (clr_err ? '0 : err_count_reg)} + (ERR_CNT_WIDTH+1)'(err_pop);
    err_count_next = count_sum[ERR_CNT_WIDTH] ? '1 : count_sum[ERR_CNT_WIDTH-1:0];

    cap_valid_next = clr_err ? 1'b0 : cap_valid_reg;
    cap_data_next  = clr_err ? '0   : cap_data_reg;
    if ((|err_hit) && !cap_valid_next) begin
      cap_valid_next = 1'b1;
      cap_data_next  = s1_data_reg;
    end
  end

  // Stage 1 data capture; its validity is tracked separately so no reset is needed
  always_ff @(posedge clk) begin
    s1_data_reg <= din;
  end

  // Stage 1 valid, stage 2 outputs and status registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg   <= 1'b0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      word_err_reg   <= '0;
      err_sticky_reg <= '0;
      err_count_reg  <= '0;
      cap_valid_reg  <= 1'b0;
      cap_data_reg   <= '0;
    end else begin
      s1_valid_reg   <= din_valid;
      dout_reg       <= stripped;
      dout_valid_reg <= s1_valid_reg;
      word_err_reg   <= err_hit;
      err_sticky_reg <= err_sticky_next;
      err_count_reg  <= err_count_next;
      cap_valid_reg  <= cap_valid_next;
      cap_data_reg   <= cap_data_next;
    end
  end

  assign dout       = dout_reg;
  assign dout_valid = dout_valid_reg;
  assign word_err   = word_err_reg;
  assign any_err    = dout_valid_reg & (|word_err_reg);
  assign err_sticky = err_sticky_reg;
  assign err_count  = err_count_reg;
  assign cap_valid  = cap_valid_reg;
  assign cap_data   = cap_data_reg;

endmodule
